// File: rtl/fsm_seq_pkg.sv
// ---------------------------------------------------------------
// fsm_seq_pkg : shared constants, types and helpers for fsm_seq
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package fsm_seq_pkg;

   localparam int CODE_EN_DEF  = 10;
   localparam int CODE_DIS_DEF = 5;
   localparam int RST_CODE_DEF = 0;

   typedef enum logic {
      DEC_DIS = 1'b0,
      DEC_EN  = 1'b1
   } dec_e;

   // Never below 1 bit, so a two-step ring still gets a usable index.
   function automatic int step_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_seq_if.sv
// ---------------------------------------------------------------
// fsm_seq_if : control inputs and status outputs of fsm_seq
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface fsm_seq_if #(
   parameter int OUT_W = 4,
   parameter int SW    = 3,
   parameter int CNT_W = 8
);
   logic             enable;
   logic             pause;
   logic             clear;
   logic [OUT_W-1:0] out;
   logic [SW-1:0]    step;
   logic             wrap;
   logic [CNT_W-1:0] lap_cnt;

   modport master (
      output enable, pause, clear,
      input  out, step, wrap, lap_cnt
   );

   modport slave (
      input  enable, pause, clear,
      output out, step, wrap, lap_cnt
   );
endinterface

`default_nettype wire

// File: rtl/fsm_seq_dwell.sv
// ---------------------------------------------------------------
// fsm_seq_dwell : per-step dwell counter, flags the last count
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fsm_seq_dwell #(
   parameter int DWELL = 1
) (
   input  logic clk,
   input  logic rstb,
   input  logic clr_i,
   input  logic adv_i,
   output logic last_o
);
   localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign last_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (adv_i) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fsm_seq.sv
// ---------------------------------------------------------------
// fsm_seq : step-ring sequencer with dwell, pause/clear and lap count
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fsm_seq
   import fsm_seq_pkg::*;
#(
   parameter int NUM_STEPS   = 6,
   parameter int BRANCH_STEP = 3,
   parameter int DWELL       = 1,
   parameter int OUT_W       = 4,
   parameter int CODE_EN     = CODE_EN_DEF,
   parameter int CODE_DIS    = CODE_DIS_DEF,
   parameter int RST_CODE    = RST_CODE_DEF,
   parameter int CNT_W       = 8
) (
   input  logic      clk,
   input  logic      rstb,
   fsm_seq_if.slave  bus
);
   localparam int               SW        = step_width(NUM_STEPS);
   localparam logic [SW-1:0]    LAST_STEP = SW'(NUM_STEPS - 1);
   localparam logic [SW-1:0]    BR_STEP   = SW'(BRANCH_STEP);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   if (NUM_STEPS < 2) begin : g_bad_steps
      $error("fsm_seq: NUM_STEPS must be >= 2");
   end
   if (BRANCH_STEP < 1 || BRANCH_STEP >= NUM_STEPS) begin : g_bad_branch
      $error("fsm_seq: BRANCH_STEP must be in 1..NUM_STEPS-1");
   end
   if (DWELL < 1) begin : g_bad_dwell
      $error("fsm_seq: DWELL must be >= 1");
   end
   if (CODE_EN < 0 || CODE_EN >= (1 << OUT_W) || CODE_DIS < 0 || CODE_DIS >= (1 << OUT_W)
       || RST_CODE < 0 || RST_CODE >= (1 << OUT_W)) begin : g_bad_code
      $error("fsm_seq: output codes must fit OUT_W");
   end

   logic [SW-1:0]    step_q, step_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] lap_q, lap_d;
   logic             home;
   logic             dwell_last;
   dec_e             dec;

   assign home = (step_q == '0);
   assign dec  = bus.enable ? DEC_EN : DEC_DIS;

   // Home lasts one cycle, so the dwell counter only runs in non-home steps.
   fsm_seq_dwell #(.DWELL(DWELL)) u_dwell (
      .clk    (clk),
      .rstb   (rstb),
      .clr_i  (bus.clear),
      .adv_i  (!bus.clear && !bus.pause && !home),
      .last_o (dwell_last)
   );

   always_comb begin
      step_d = step_q;
      out_d  = out_q;
      wrap_d = 1'b0;
      lap_d  = lap_q;
      if (bus.clear) begin
         step_d = '0;
         out_d  = OUT_W'(RST_CODE);
      end else if (!bus.pause) begin
         if (home) begin
            if (dec == DEC_EN) begin
               step_d = SW'(1);
               out_d  = OUT_W'(CODE_EN);
            end else begin
               step_d = BR_STEP;
               out_d  = OUT_W'(CODE_DIS);
            end
         end else if (dwell_last) begin
            if (step_q == LAST_STEP) begin
               step_d = '0;
               wrap_d = 1'b1;
               if (lap_q != CNT_MAX) begin
                  lap_d = lap_q + 1'b1;
               end
            end else begin
               step_d = step_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         step_q <= '0;
         out_q  <= OUT_W'(RST_CODE);
         wrap_q <= 1'b0;
         lap_q  <= '0;
      end else begin
         step_q <= step_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
         lap_q  <= lap_d;
      end
   end

   assign bus.step    = step_q;
   assign bus.out     = out_q;
   assign bus.wrap    = wrap_q;
   assign bus.lap_cnt = lap_q;

endmodule

`default_nettype wire
